// File: rtl/mips_defs.sv
// Shared MIPS EX-stage definitions: divide ALU opcodes and divider FSM state encoding.
package mips_defs;

    localparam logic [5:0] ALUOP_DIV  = 6'b011100;
    localparam logic [5:0] ALUOP_DIVU = 6'b001100;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    function automatic logic is_div_op(input logic [5:0] aluop);
        return (aluop == ALUOP_DIV) || (aluop == ALUOP_DIVU);
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step
    import mips_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted_s;
    logic           fits_s;

    // The shifted remainder can reach 2*divisor-1, so the trial compare is one bit wider.
    always_comb begin
        shifted_s = {rem_in, quo_in[WIDTH-1]};
        fits_s    = (shifted_s >= {1'b0, divisor});
        quo_out   = {quo_in[WIDTH-2:0], fits_s};
        if (fits_s) begin
            rem_out = shifted_s[WIDTH-1:0] - divisor;
        end else begin
            rem_out = shifted_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (div/divu) producing LO=quotient, HI=remainder.
module div_unit
    import mips_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic             annul,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic             valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    div_state_e       state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r, quo_r, div_r, hi_r, lo_r;
    logic             neg_quo_r, neg_rem_r, valid_r;
    logic [WIDTH-1:0] rem_step_s, quo_step_s, a_mag_s, b_mag_s;
    logic             start_ok_s, b_zero_s;

    assign start_ok_s = start & ~annul;
    assign b_zero_s   = (b == {WIDTH{1'b0}});
    // 0x80000000 maps onto itself, which is the correct unsigned magnitude 2^(WIDTH-1).
    assign a_mag_s    = (is_signed && a[WIDTH-1]) ? negate(a) : a;
    assign b_mag_s    = (is_signed && b[WIDTH-1]) ? negate(b) : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_r),
        .quo_in  (quo_r),
        .divisor (div_r),
        .rem_out (rem_step_s),
        .quo_out (quo_step_s)
    );

    // Next-state and stall decode; stall drops in DONE so the consumer advances with valid.
    always_comb begin
        state_next_s = state_r;
        stall        = 1'b0;
        case (state_r)
            DIV_IDLE: begin
                if (start_ok_s) begin
                    stall        = 1'b1;
                    state_next_s = b_zero_s ? DIV_DONE : DIV_BUSY;
                end else begin
                    state_next_s = DIV_IDLE;
                end
            end
            DIV_BUSY: begin
                stall = 1'b1;
                if (annul) begin
                    state_next_s = DIV_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = DIV_FIX;
                end else begin
                    state_next_s = DIV_BUSY;
                end
            end
            DIV_FIX: begin
                stall        = 1'b1;
                state_next_s = annul ? DIV_IDLE : DIV_DONE;
            end
            DIV_DONE: state_next_s = DIV_IDLE;
            default:  state_next_s = DIV_IDLE;
        endcase
    end

    // State, datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= DIV_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            quo_r     <= {WIDTH{1'b0}};
            div_r     <= {WIDTH{1'b0}};
            neg_quo_r <= 1'b0;
            neg_rem_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            valid_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            valid_r <= (state_next_s == DIV_DONE);
            case (state_r)
                DIV_IDLE: begin
                    if (start_ok_s && b_zero_s) begin
                        hi_r <= a;
                        lo_r <= {WIDTH{1'b1}};
                    end else if (start_ok_s) begin
                        rem_r     <= {WIDTH{1'b0}};
                        quo_r     <= a_mag_s;
                        div_r     <= b_mag_s;
                        neg_quo_r <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_r <= is_signed & a[WIDTH-1];
                        cnt_r     <= {CNT_W{1'b0}};
                    end
                end
                DIV_BUSY: begin
                    if (!annul) begin
                        rem_r <= rem_step_s;
                        quo_r <= quo_step_s;
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DIV_FIX: begin
                    if (!annul) begin
                        lo_r <= neg_quo_r ? negate(quo_r) : quo_r;
                        hi_r <= neg_rem_r ? negate(rem_r) : rem_r;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valid = valid_r;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table plus scoreboard, and hand sequences for annul/reset/ignored start.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        stall, valid;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    logic [63:0] sb_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;
    vec_t vecs[12];

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .annul     (annul),
        .a         (a),
        .b         (b),
        .stall     (stall),
        .valid     (valid),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [31:0] xm, ym, q, r;
        logic [63:0] q64, r64;
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        xm  = (s && x[31]) ? (32'd0 - x) : x;
        ym  = (s && y[31]) ? (32'd0 - y) : y;
        q64 = {32'd0, xm} / {32'd0, ym};
        r64 = {32'd0, xm} % {32'd0, ym};
        q   = q64[31:0];
        r   = r64[31:0];
        if (s && (x[31] ^ y[31])) q = 32'd0 - q;
        if (s && x[31]) r = 32'd0 - r;
        return {r, q};
    endfunction

    // Scoreboard: every valid pulse must match the oldest outstanding expected result.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            logic [63:0] e;
            valid_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=1 expected no result pending");
            end else begin
                e = sb_q.pop_front();
                chk("sb_hi", hi, e[63:32]);
                chk("sb_lo", lo, e[31:0]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat;
        logic prof_ok;
        next_cycle();
        start = 1'b1; a = x; b = y; is_signed = s;
        sb_q.push_back({exp_hi, exp_lo});
        lat = (y == 32'd0) ? 1 : 34;
        prof_ok = 1'b1;
        for (int k = 0; k <= lat + 2; k++) begin
            @(negedge clk);
            if (stall !== (k < lat)) prof_ok = 1'b0;
            if (valid !== (k == lat)) prof_ok = 1'b0;
            next_cycle();
            start = 1'b0;
        end
        chk("stall_valid_profile", {31'd0, prof_ok}, 32'd1);
        @(negedge clk);
        chk("held_hi", hi, exp_hi);
        chk("held_lo", lo, exp_lo);
    endtask

    initial begin
        int got;
        int v0;
        logic [31:0] rx, ry;
        logic        rs;
        logic [63:0] m;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 32'd2,          32'd14};
        vecs[1]  = '{32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFD};
        vecs[2]  = '{32'd7,          32'hFFFFFFFE,   1'b1, 32'd1,          32'hFFFFFFFD};
        vecs[3]  = '{32'h80000000,   32'hFFFFFFFF,   1'b1, 32'd0,          32'h80000000};
        vecs[4]  = '{32'd5,          32'd0,          1'b0, 32'd5,          32'hFFFFFFFF};
        vecs[5]  = '{32'hFFFFFFFF,   32'd1,          1'b0, 32'd0,          32'hFFFFFFFF};
        vecs[6]  = '{32'hFFFFFFF9,   32'hFFFFFFFE,   1'b1, 32'hFFFFFFFF,   32'd3};
        vecs[7]  = '{32'hFFFFFFFF,   32'h00000010,   1'b0, 32'h0000000F,   32'h0FFFFFFF};
        vecs[8]  = '{32'h80000000,   32'd2,          1'b1, 32'd0,          32'hC0000000};
        vecs[9]  = '{32'd3,          32'd7,          1'b0, 32'd3,          32'd0};
        vecs[10] = '{32'd0,          32'hFFFFFFFB,   1'b1, 32'd0,          32'd0};
        vecs[11] = '{32'hFFFFFFFB,   32'd0,          1'b1, 32'hFFFFFFFB,   32'hFFFFFFFF};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_valid", {31'd0, valid}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].hi, vecs[i].lo);
        end

        for (int i = 0; i < 8; i++) begin
            rx = $urandom;
            ry = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            rs = 1'(i % 2);
            m  = model(rx, ry, rs);
            run_op(rx, ry, rs, m[63:32], m[31:0]);
        end

        // Start pulsed mid-divide must be ignored; 100/7 still lands in cycle 34.
        next_cycle();
        start = 1'b1; a = 32'd100; b = 32'd7; is_signed = 1'b0;
        sb_q.push_back({32'd2, 32'd14});
        got = -1;
        for (int c = 1; c <= 37; c++) begin
            next_cycle();
            start = (c == 5);
            if (c == 5) begin a = 32'd999; b = 32'd1; end
            @(negedge clk);
            if (valid === 1'b1 && got < 0) got = c;
        end
        chk("ignored_start_latency", got, 32'd34);

        // Annul in cycle 10 of a divide.
        v0 = valid_cnt;
        next_cycle();
        start = 1'b1; a = 32'd1000; b = 32'd3; is_signed = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            start = 1'b0;
        end
        annul = 1'b1;
        @(negedge clk);
        chk("annul_stall_c10", {31'd0, stall}, 32'd1);
        next_cycle();
        annul = 1'b0;
        @(negedge clk);
        chk("annul_stall_c11", {31'd0, stall}, 32'd0);
        repeat (40) next_cycle();
        chk("annul_no_valid", valid_cnt, v0);
        chk("annul_hi", hi, 32'd2);
        chk("annul_lo", lo, 32'd14);

        // Annul outranks start in the same cycle.
        next_cycle();
        start = 1'b1; annul = 1'b1; a = 32'd20; b = 32'd3;
        @(negedge clk);
        chk("annul_start_stall", {31'd0, stall}, 32'd0);
        next_cycle();
        start = 1'b0; annul = 1'b0;
        @(negedge clk);
        chk("annul_start_idle", {31'd0, stall}, 32'd0);

        // Annul during FIX (cycle 33).
        next_cycle();
        start = 1'b1; a = 32'd1000; b = 32'd3;
        for (int c = 1; c <= 33; c++) begin
            next_cycle();
            start = 1'b0;
        end
        annul = 1'b1;
        @(negedge clk);
        chk("fix_annul_stall_c33", {31'd0, stall}, 32'd1);
        next_cycle();
        annul = 1'b0;
        @(negedge clk);
        chk("fix_annul_valid_c34", {31'd0, valid}, 32'd0);
        chk("fix_annul_stall_c34", {31'd0, stall}, 32'd0);
        repeat (5) next_cycle();
        chk("fix_annul_no_valid", valid_cnt, v0);
        chk("fix_annul_hi", hi, 32'd2);
        chk("fix_annul_lo", lo, 32'd14);

        // Reset in cycle 20 aborts the divide and clears outputs.
        next_cycle();
        start = 1'b1; a = 32'd50; b = 32'd3;
        for (int c = 1; c <= 20; c++) begin
            next_cycle();
            start = 1'b0;
            if (c == 20) rst = 1'b1;
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_stall", {31'd0, stall}, 32'd0);
        chk("rst_mid_valid", {31'd0, valid}, 32'd0);
        chk("rst_mid_hi", hi, 32'd0);
        chk("rst_mid_lo", lo, 32'd0);
        repeat (40) next_cycle();
        chk("rst_mid_no_valid", valid_cnt, v0);
        run_op(32'd9, 32'd3, 1'b0, 32'd0, 32'd3);

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
